// File: rtl/dmem_lsu_ctrl.sv
// Load/store sequencer for a word-wide data memory with a single write enable.
// Sub-word stores are read-modify-write; define DMEM_ALIGN_CHECK_EN to reject misaligned h/hu/w.
module dmem_lsu_ctrl #(
  parameter int ADDR_W    = 32,
  parameter int MEM_BYTES = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_i,
  output logic              ready_o,
  input  logic              we_i,
  input  logic [2:0]        size_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       wdata_i,
  output logic              done_o,
  output logic              err_o,
  output logic [31:0]       rdata_o,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  localparam logic [2:0] SZ_B  = 3'b000;
  localparam logic [2:0] SZ_H  = 3'b001;
  localparam logic [2:0] SZ_W  = 3'b010;
  localparam logic [2:0] SZ_BU = 3'b100;
  localparam logic [2:0] SZ_HU = 3'b101;
  localparam logic [ADDR_W-1:0] MEM_LIMIT = ADDR_W'(MEM_BYTES);

  typedef enum logic [1:0] {IDLE, ACCESS, WRITE, RESP} state_t;

  state_t      state;
  logic        we_q;
  logic [2:0]  size_q;
  logic [1:0]  lane_q;
  logic [15:0] wdata_q;
  logic        mem_we_q;

  logic        size_bad;
  logic        store_bad;
  logic        range_bad;
  logic        align_bad;
  logic        req_illegal;
  logic        word_store;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_ext;
  logic [31:0] st_merge;

  // Reset must kill a write in the same cycle, so the enable is gated combinationally.
  assign mem_we = mem_we_q & ~rst;

  always_comb begin
    size_bad   = (size_i == 3'b011) || (size_i == 3'b110) || (size_i == 3'b111);
    store_bad  = we_i && size_i[2];
    range_bad  = addr_i >= MEM_LIMIT;
`ifdef DMEM_ALIGN_CHECK_EN
    align_bad  = ((size_i[1:0] == 2'b01) && addr_i[0]) ||
                 ((size_i == SZ_W) && (addr_i[1:0] != 2'b00));
`else
    align_bad  = 1'b0;
`endif
    req_illegal = size_bad | store_bad | range_bad | align_bad;
    word_store  = we_i && (size_i == SZ_W);
  end

  always_comb begin
    case (lane_q)
      2'd0:    ld_byte = mem_rdata[7:0];
      2'd1:    ld_byte = mem_rdata[15:8];
      2'd2:    ld_byte = mem_rdata[23:16];
      default: ld_byte = mem_rdata[31:24];
    endcase
    ld_half = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (size_q)
      SZ_B:    ld_ext = {{24{ld_byte[7]}}, ld_byte};
      SZ_BU:   ld_ext = {24'h0, ld_byte};
      SZ_H:    ld_ext = {{16{ld_half[15]}}, ld_half};
      SZ_HU:   ld_ext = {16'h0, ld_half};
      default: ld_ext = mem_rdata;
    endcase
  end

  // Only sizes 000 (byte) and 001 (half) reach the merge path.
  always_comb begin
    st_merge = mem_rdata;
    if (size_q[0] == 1'b0) begin
      case (lane_q)
        2'd0:    st_merge[7:0]   = wdata_q[7:0];
        2'd1:    st_merge[15:8]  = wdata_q[7:0];
        2'd2:    st_merge[23:16] = wdata_q[7:0];
        default: st_merge[31:24] = wdata_q[7:0];
      endcase
    end else if (lane_q[1]) begin
      st_merge[31:16] = wdata_q;
    end else begin
      st_merge[15:0]  = wdata_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ready_o   <= 1'b1;
      done_o    <= 1'b0;
      err_o     <= 1'b0;
      rdata_o   <= 32'h0;
      mem_we_q  <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= 32'h0;
      we_q      <= 1'b0;
      size_q    <= 3'b000;
      lane_q    <= 2'b00;
      wdata_q   <= 16'h0;
    end else begin
      case (state)
        IDLE: begin
          if (req_i && ready_o) begin
            we_q    <= we_i;
            size_q  <= size_i;
            lane_q  <= addr_i[1:0];
            wdata_q <= wdata_i[15:0];
            ready_o <= 1'b0;
            if (req_illegal) begin
              state  <= RESP;
              done_o <= 1'b1;
              err_o  <= 1'b1;
            end else begin
              state     <= ACCESS;
              mem_addr  <= {addr_i[ADDR_W-1:2], 2'b00};
              mem_we_q  <= word_store;
              mem_wdata <= word_store ? wdata_i : 32'h0;
            end
          end
        end
        ACCESS: begin
          if (!we_q) begin
            rdata_o  <= ld_ext;
            mem_addr <= '0;
            done_o   <= 1'b1;
            state    <= RESP;
          end else if (size_q == SZ_W) begin
            mem_we_q  <= 1'b0;
            mem_wdata <= 32'h0;
            mem_addr  <= '0;
            done_o    <= 1'b1;
            state     <= RESP;
          end else begin
            mem_wdata <= st_merge;
            mem_we_q  <= 1'b1;
            state     <= WRITE;
          end
        end
        WRITE: begin
          mem_we_q  <= 1'b0;
          mem_wdata <= 32'h0;
          mem_addr  <= '0;
          done_o    <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          done_o  <= 1'b0;
          err_o   <= 1'b0;
          ready_o <= 1'b1;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_lsu_ctrl.sv
// Bench for dmem_lsu_ctrl: byte-array memory model, per-cycle compare against op timing table.
module tb_dmem_lsu_ctrl;
  localparam int ADDR_W    = 32;
  localparam int MEM_BYTES = 1024;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_i = 1'b0;
  logic        we_i = 1'b0;
  logic [2:0]  size_i = 3'b000;
  logic [31:0] addr_i = 32'h0;
  logic [31:0] wdata_i = 32'h0;
  logic        ready_o, done_o, err_o, mem_we;
  logic [31:0] rdata_o, mem_addr, mem_wdata, mem_rdata;

  dmem_lsu_ctrl #(.ADDR_W(ADDR_W), .MEM_BYTES(MEM_BYTES)) dut (
    .clk(clk), .rst(rst), .req_i(req_i), .ready_o(ready_o), .we_i(we_i),
    .size_i(size_i), .addr_i(addr_i), .wdata_i(wdata_i), .done_o(done_o),
    .err_o(err_o), .rdata_o(rdata_o), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Word memory seen by the DUT
  logic [31:0] mem [0:255];
  assign mem_rdata = mem[mem_addr[9:2]];
  always @(posedge clk) if (mem_we) mem[mem_addr[9:2]] <= mem_wdata;

  // Reference model: byte array plus the op currently in flight
  logic [7:0]  rb [0:MEM_BYTES-1];
  bit          op_active = 0, op_we, op_err, op_load;
  int          op_lat, op_cyc, op_we_cnt;
  logic [31:0] op_addr, op_rdata, op_wword, op_old;
  logic [31:0] exp_rdata = 32'h0;
  bit          post_rst = 0;
  int          last_lat, last_we;
  logic        last_err;

  int n_chk = 0, n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit legal(bit we, logic [2:0] sz, logic [31:0] a);
    if (sz == 3'b011 || sz == 3'b110 || sz == 3'b111) return 0;
    if (we && sz[2]) return 0;
    if (a >= MEM_BYTES) return 0;
`ifdef DMEM_ALIGN_CHECK_EN
    if ((sz == 3'b001 || sz == 3'b101) && a[0]) return 0;
    if (sz == 3'b010 && a[1:0] != 2'b00) return 0;
`endif
    return 1;
  endfunction

  function automatic logic [31:0] word_at(logic [31:0] a);
    int i;
    i = int'(a[9:0]) & ~3;
    return {rb[i+3], rb[i+2], rb[i+1], rb[i]};
  endfunction

  function automatic logic [31:0] ld_model(logic [2:0] sz, logic [31:0] a);
    int i;
    i = int'(a[9:0]);
    case (sz)
      3'b000: return {{24{rb[i][7]}}, rb[i]};
      3'b100: return {24'h0, rb[i]};
      3'b001: begin i = i & ~1; return {{16{rb[i+1][7]}}, rb[i+1], rb[i]}; end
      3'b101: begin i = i & ~1; return {16'h0, rb[i+1], rb[i]}; end
      default: return word_at(a);
    endcase
  endfunction

  task automatic put_word(input logic [31:0] a, input logic [31:0] w);
    int i;
    i = int'(a[9:0]) & ~3;
    rb[i] = w[7:0]; rb[i+1] = w[15:8]; rb[i+2] = w[23:16]; rb[i+3] = w[31:24];
  endtask

  task automatic st_model(input logic [2:0] sz, input logic [31:0] a, input logic [31:0] wd);
    int i;
    i = int'(a[9:0]);
    case (sz)
      3'b000: rb[i] = wd[7:0];
      3'b001: begin i = i & ~1; rb[i] = wd[7:0]; rb[i+1] = wd[15:8]; end
      default: put_word(a, wd);
    endcase
  endtask

  // Single compare process
  always @(negedge clk) begin : cmp
    bit dn, we_e;
    logic [31:0] ea;
    if (rst) begin
      chk("mem_we_in_reset", {31'h0, mem_we}, 32'h0);
      if (op_active && op_we && !op_err && (op_cyc + 1 < op_lat)) put_word(op_addr, op_old);
      op_active = 0;
      exp_rdata = 32'h0;
      post_rst  = 1;
    end else begin
      dn = 0; we_e = 0; ea = 32'h0;
      if (op_active) begin
        op_cyc++;
        dn   = (op_cyc == op_lat);
        we_e = !op_err && op_we && (op_cyc == op_lat - 1);
        if (!op_err && op_cyc < op_lat) ea = op_addr & ~32'h3;
        if (dn && op_load && !op_err) exp_rdata = op_rdata;
        op_we_cnt += int'(mem_we);
      end
      chk("ready_o",  {31'h0, ready_o}, {31'h0, !op_active});
      chk("done_o",   {31'h0, done_o},  {31'h0, dn});
      chk("err_o",    {31'h0, err_o},   {31'h0, dn && op_err});
      chk("rdata_o",  rdata_o, exp_rdata);
      chk("mem_we",   {31'h0, mem_we},  {31'h0, we_e});
      chk("mem_addr", mem_addr, ea);
      if (we_e) chk("mem_wdata", mem_wdata, op_wword);
      if (post_rst) begin
        chk("reset_mem_wdata", mem_wdata, 32'h0);
        post_rst = 0;
      end
      if (dn) begin
        last_lat  = op_cyc;
        last_err  = err_o;
        last_we   = op_we_cnt;
        op_active = 0;
      end
    end
  end

  task automatic issue(input bit we, input logic [2:0] sz, input logic [31:0] a,
                       input logic [31:0] wd, input bit rst_mid);
    int  lat;
    bit  ok;
    ok  = legal(we, sz, a);
    lat = !ok ? 1 : ((!we || sz == 3'b010) ? 2 : 3);
    req_i = 1'b1; we_i = we; size_i = sz; addr_i = a; wdata_i = wd;
    @(posedge clk); #1;
    op_we = we; op_err = !ok; op_load = !we; op_lat = lat;
    op_addr = a; op_cyc = 0; op_we_cnt = 0;
    op_rdata = (ok && !we) ? ld_model(sz, a) : 32'h0;
    if (ok && we) begin
      op_old = word_at(a);
      st_model(sz, a, wd);
      op_wword = word_at(a);
    end
    op_active = 1;
    if (rst_mid) begin
      req_i = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
    end else begin
      // Requests presented while busy must be ignored
      for (int i = 0; i < lat; i++) begin
        req_i = 1'($urandom_range(0, 1)); we_i = 1'($urandom_range(0, 1));
        size_i = 3'($urandom); addr_i = $urandom; wdata_i = $urandom;
        @(posedge clk); #1;
      end
    end
    req_i = 1'b0;
  endtask

  task automatic pin_op(input string nm, input int lat, input logic err, input int wes);
    chk({nm, "_lat"}, 32'(last_lat), 32'(lat));
    chk({nm, "_err"}, {31'h0, last_err}, {31'h0, err});
    chk({nm, "_we_cnt"}, 32'(last_we), 32'(wes));
  endtask

  logic [2:0] sz_tab [0:11];

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    for (int i = 0; i < MEM_BYTES; i++) rb[i] = 8'h0;
    sz_tab[0] = 3'b000; sz_tab[1] = 3'b001; sz_tab[2] = 3'b010; sz_tab[3]  = 3'b010;
    sz_tab[4] = 3'b100; sz_tab[5] = 3'b101; sz_tab[6] = 3'b000; sz_tab[7]  = 3'b001;
    sz_tab[8] = 3'b011; sz_tab[9] = 3'b110; sz_tab[10] = 3'b111; sz_tab[11] = 3'b010;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    issue(1, 3'b010, 32'h10, 32'hDEADBEEF, 0); pin_op("sw", 2, 1'b0, 1);
    issue(0, 3'b010, 32'h10, 32'h0, 0);        pin_op("lw", 2, 1'b0, 0);
    chk("lw_10", rdata_o, 32'hDEADBEEF);
    issue(1, 3'b000, 32'h12, 32'h5A, 0);       pin_op("sb", 3, 1'b0, 1);
    issue(0, 3'b010, 32'h10, 32'h0, 0);        chk("lw_after_sb", rdata_o, 32'hDE5ABEEF);
    issue(0, 3'b000, 32'h13, 32'h0, 0);        chk("lb_13",  rdata_o, 32'hFFFFFFDE);
    issue(0, 3'b100, 32'h13, 32'h0, 0);        chk("lbu_13", rdata_o, 32'h000000DE);
    issue(0, 3'b001, 32'h12, 32'h0, 0);        chk("lh_12",  rdata_o, 32'hFFFFDE5A);
    issue(0, 3'b101, 32'h12, 32'h0, 0);        chk("lhu_12", rdata_o, 32'h0000DE5A);
    issue(0, 3'b010, 32'h11, 32'h0, 0);
`ifdef DMEM_ALIGN_CHECK_EN
    pin_op("lw_mis", 1, 1'b1, 0);
`else
    pin_op("lw_mis", 2, 1'b0, 0);
    chk("lw_11", rdata_o, 32'hDE5ABEEF);
`endif
    issue(1, 3'b010, 32'h400, 32'h11111111, 0); pin_op("sw_oor", 1, 1'b1, 0);
    issue(0, 3'b011, 32'h10, 32'h0, 0);         pin_op("ld_sz3", 1, 1'b1, 0);
    issue(1, 3'b100, 32'h10, 32'h22, 0);        pin_op("sbu",    1, 1'b1, 0);
    issue(0, 3'b010, 32'h10, 32'h0, 0);         chk("lw_after_err", rdata_o, 32'hDE5ABEEF);
    issue(1, 3'b001, 32'h10, 32'h1234, 1);
    chk("rst_ready", {31'h0, ready_o}, 32'h1);
    chk("rst_done",  {31'h0, done_o},  32'h0);
    issue(0, 3'b010, 32'h10, 32'h0, 0);         chk("lw_after_rst", rdata_o, 32'hDE5ABEEF);

    for (int n = 0; n < 400; n++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 9) == 0) ? 32'($urandom_range(1000, 1100)) : 32'($urandom_range(0, 63));
      issue(1'($urandom_range(0, 1)), sz_tab[$urandom_range(0, 11)], a, $urandom, 0);
      if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
    end

    for (int i = 0; i < 256; i++) chk("mem_image", mem[i], word_at(32'(i * 4)));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/dmem_lsu_ctrl.md
Name: dmem_lsu_ctrl

Overview:
- Load/store controller between the core's memory stage and the word-wide data memory.
- The data memory has only a full 32-bit write enable, no byte strobes.
- Sequences byte/halfword/word loads and stores; sub-word stores use read-modify-write on the aligned word.
- Performs sign/zero extension on loads and flags illegal requests.

Parameters:
- ADDR_W, 32, request and memory address width.
- MEM_BYTES, 1024, data memory size in bytes; addresses >= MEM_BYTES are out of range.

Ports:
- clk  input  1  clock; all state changes on rising edge
- rst  input  1  synchronous active-high reset
- req_i  input  1  request valid
- ready_o  output  1  controller idle, request accepted this cycle if req_i=1
- we_i  input  1  1=store, 0=load
- size_i  input  3  funct3 encoding: 000 b, 001 h, 010 w, 100 bu, 101 hu
- addr_i  input  ADDR_W  byte address
- wdata_i  input  32  store data, low bits used for b/h
- done_o  output  1  one-cycle response pulse
- err_o  output  1  valid with done_o: request rejected, no memory effect
- rdata_o  output  32  extended load data, valid with done_o
- mem_we  output  1  to data memory WE
- mem_addr  output  ADDR_W  to data memory addr, always word-aligned (bits [1:0]=0)
- mem_wdata  output  32  to data memory write_data
- mem_rdata  input  32  from data memory read_data; combinational read, write on rising edge

Behaviour:
- States: IDLE, ACCESS, WRITE, RESP. Reset forces IDLE.
- Reset values: done_o=0, err_o=0, rdata_o=0, mem_we=0, mem_addr=0, mem_wdata=0, ready_o=1.
- ready_o=1 only in IDLE.
- Accept: req_i & ready_o registers we_i, size_i, addr_i and wdata_i. No other input is sampled afterwards.
- Legality is checked at accept. A request is illegal if any of:
  - size_i is 011, 110 or 111;
  - it is a store with size_i 100 or 101;
  - addr_i >= MEM_BYTES;
  - it is misaligned (see Optional Feature).
- Illegal request: IDLE -> RESP with err_o=1. mem_we stays 0 throughout.
- Legal request: IDLE -> ACCESS. mem_addr = {addr_q[ADDR_W-1:2],2'b00} in ACCESS and WRITE, else 0.
- Load in ACCESS:
  - mem_we=0.
  - Select byte addr_q[1:0] or half addr_q[1], then sign-extend (b/h) or zero-extend (bu/hu).
  - Register the result into rdata_o; go to RESP.
  - Latency: done_o asserted in the 2nd cycle after the accept cycle.
- Word store in ACCESS: mem_we=1, mem_wdata=wdata_q; go to RESP.
- Sub-word store in ACCESS:
  - mem_we=0.
  - Merge wdata_q[7:0] or wdata_q[15:0] into mem_rdata at the selected lane; register the merged word.
  - Go to WRITE.
- Sub-word store in WRITE: mem_we=1, mem_wdata=merged word; go to RESP.
- RESP: done_o=1 for exactly one cycle, then IDLE. err_o=0 for legal requests. rdata_o holds its value until the next load's ACCESS. Stores leave rdata_o unchanged.
- Throughput: 1 op per 3 cycles (4 for sub-word store); no request overlap.
- mem_we is 0 outside ACCESS/WRITE and is forced 0 in any cycle with rst=1.
- Reset mid-operation: state -> IDLE, outputs -> reset values.
  - If reset lands in ACCESS of an RMW, memory is untouched.
  - A WRITE cycle is either completed before the reset edge or not started.
- req_i held high while ready_o=0 is ignored; no queueing.

Optional Feature:
- Macro: DMEM_ALIGN_CHECK_EN.
- Defined: h/hu with addr_i[0]=1, or w with addr_i[1:0]!=0, is illegal (err_o=1, no access).
- Undefined:
  - Low address bits are forced to alignment: h/hu ignore addr_i[0]; w ignores addr_i[1:0].
  - Such requests are never errors.
  - Out-of-range and bad size still raise err_o.

Test Plan:
- sw 0xDEADBEEF @0x10, then lw @0x10 -> mem_we pulses exactly 1 cycle in ACCESS; lw gives done_o 2 cycles after accept, rdata_o=0xDEADBEEF, err_o=0.
- sb 0x5A @0x12 after the above; lw @0x10 -> sb takes 4 cycles and mem_we is high only in WRITE; lw returns 0xDE5ABEEF.
- lb @0x13 -> 0xFFFFFFDE; lbu @0x13 -> 0x000000DE; lh @0x12 -> 0xFFFFDE5A; lhu @0x12 -> 0x0000DE5A.
- With DMEM_ALIGN_CHECK_EN: lw @0x11 -> done_o+err_o 1 cycle after accept, mem_we=0. Without it: lw @0x11 returns the word @0x10, err_o=0.
- sw @0x400 (MEM_BYTES=1024), size 011 load, sb with size 100 -> each err_o=1, memory unchanged (readback lw @0x10 still 0xDE5ABEEF).
- sh 0x1234 @0x10 with rst=1 asserted in its WRITE-preceding ACCESS cycle -> ready_o=1 next cycle, done_o never pulses, lw @0x10 returns the pre-store 0xDE5ABEEF.
